instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/pc_reg.sv | 33 +++
 rtl/instr_fetch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, NOP word and
// default reset vector.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-align an address by clearing its two low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load (redirect) and increment-by-4 controls.
// Load wins over increment; pc_plus4 is purely combinational.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        incr,
  input  logic [31:0] load_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_value_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_value_reg <= RESET_PC;
    end else if (load) begin
      pc_value_reg <= load_pc;
    end else if (incr) begin
      pc_value_reg <= pc_plus4;
    end
  end

  assign pc       = pc_value_reg;
  // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
  assign pc_plus4 = pc_value_reg + 32'd4;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit (FETCH/WAIT/HOLD/HALT).
// Optional misaligned-redirect trap enabled by macro FETCH_MISALIGN_CHK_EN.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instruct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  fetch_state_t state_reg, state_next;
  logic         instr_valid_reg, instr_valid_next;
  logic [31:0]  instruct_reg, instruct_next;
  logic         kill_reg, kill_next;
  logic         pc_load, pc_incr, req_comb;
  logic         redirect_bad;
  logic [31:0]  redirect_target;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redirect_bad    = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;
`else
  assign redirect_bad    = 1'b0;
  assign redirect_target = align_word(redirect_pc);
`endif

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .incr    (pc_incr),
    .load_pc (redirect_target),
    .pc      (pc),
    .pc_plus4(pc_plus4)
  );

  always_comb begin
    state_next       = state_reg;
    instr_valid_next = instr_valid_reg;
    instruct_next    = instruct_reg;
    kill_next        = kill_reg;
    pc_load          = 1'b0;
    pc_incr          = 1'b0;
    req_comb         = 1'b0;

    if (state_reg != HALT && redirect_bad) begin
      state_next       = HALT;
      instr_valid_next = 1'b0;
      kill_next        = 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (redirect_valid) begin
            pc_load = 1'b1;
          end else begin
            req_comb   = 1'b1;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_load = 1'b1;
            if (imem_rvalid) begin
              kill_next  = 1'b0;
              state_next = FETCH;
            end else begin
              // Response for the abandoned address is still in flight.
              kill_next = 1'b1;
            end
          end else if (imem_rvalid) begin
            state_next = FETCH;
            if (kill_reg) begin
              kill_next = 1'b0;
            end else begin
              instruct_next    = imem_rdata;
              instr_valid_next = 1'b1;
              state_next       = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_load          = 1'b1;
            instr_valid_next = 1'b0;
            state_next       = FETCH;
          end else if (!stall) begin
            pc_incr          = 1'b1;
            instr_valid_next = 1'b0;
            state_next       = FETCH;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= FETCH;
      instr_valid_reg <= 1'b0;
      instruct_reg    <= NOP_INSTR;
      kill_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      instr_valid_reg <= instr_valid_next;
      instruct_reg    <= instruct_next;
      kill_reg        <= kill_next;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
    end else if (state_reg != HALT && redirect_bad) begin
      misalign_reg <= 1'b1;
    end
  end

  assign misalign_err = misalign_reg;
`else
  assign misalign_err = 1'b0;
`endif

  // Request is masked during reset so a reset cycle never issues a fetch.
  assign imem_req    = req_comb & rst_n;
  assign imem_addr   = pc;
  assign instr_valid = instr_valid_reg;
  assign instruct    = instruct_reg;

endmodule
